axp_lsu: RTL
============

// Module: axp_lsu
// PURPOSE
//  Load/store unit: the memory-side consumer of the address and byte-mask pair produced by
//  the address/mask calculator for opcodes 0A-0F and 28-2F.
//  Accepts one memory op at a time, checks alignment, drives a 64-bit aligned memory bus,
//  then returns load data (shifted, zero/sign-extended) or the store-conditional result.
//  Holds the LDx_L/STx_C lock flag. Sits between execute/address stage and the data cache/bus.
// PARAMETERS
//  LOCK_SHIFT  4   lock granularity: addr[63:LOCK_SHIFT] compared (16-byte block)
// PORTS
//  clock        in   1   single clock; all state updates on rising edge
//  reset_n      in   1   synchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   unit idle, request accepted when valid&ready
//  req_cmd      in   32  instruction word; op = cmd[31:26], ra = cmd[25:21]
//  req_addr     in   64  effective address (base + disp)
//  req_mask     in   8   size mask: 01 byte, 03 word, 0F long, FF quad
//  req_data     in   64  store data (Ra value), right-justified
//  mem_valid    out  1   bus request
//  mem_ready    in   1   bus accepts request when mem_valid&mem_ready
//  mem_we       out  1   1 = write
//  mem_addr     out  64  quadword-aligned address, [2:0] = 0
//  mem_be       out  8   byte enables
//  mem_wdata    out  64  lane-aligned write data
//  mem_rvalid   in   1   read data return (one beat)
//  mem_rdata    in   64  read data
//  lock_clear   in   1   external snoop hit; clears lock flag
//  resp_valid   out  1   result present
//  resp_ready   in   1   result consumed when valid&ready
//  resp_data    out  64  load result / STx_C success (1/0) / 0 for plain stores
//  resp_status  out  2   0 ok, 1 unaligned, 2 illegal opcode
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1 only in IDLE; mem_valid=0, resp_valid=0, lock flag=0;
//   all data outputs 0. Reset mid-op abandons the op; mem_rvalid is ignored outside WAIT.
//  FSM: IDLE -> REQ (bus op) | RESP (fault, failed STx_C); REQ -> WAIT (load, on mem_ready)
//   | RESP (store, on mem_ready); WAIT -> RESP (on mem_rvalid); RESP -> IDLE (on resp_ready).
//  Request fields registered at accept; req_* ignored outside IDLE.
//  Legal ops: 0A LDBU, 0B LDQ_U, 0C LDWU, 0D STW, 0E STB, 0F STQ_U, 28 LDL, 29 LDQ,
//   2A LDL_L, 2B LDQ_L, 2C STL, 2D STQ, 2E STL_C, 2F STQ_C; others -> status 2, no bus op.
//  Unaligned: (addr[2:0] & size-1) != 0 -> status 1, no bus op. LDQ_U/STQ_U never fault:
//   addr[2:0] forced to 0 before use.
//  mem_addr = {addr[63:3],3'b0}; mem_be = mask << addr[2:0]; mem_wdata = data << 8*addr[2:0].
//  mem_valid, mem_we, mem_addr, mem_be, mem_wdata stay stable from entering REQ until
//   mem_ready is sampled high.
//  Load result: rdata >> 8*addr[2:0], then byte/word zero-extended, long sign-extended
//   from bit 31, quad unchanged.
//  LDx_L: at RESP entry set lock=1 and lock_addr=addr[63:LOCK_SHIFT].
//  STx_C: issues the write only if lock=1 && lock_addr match, evaluated in IDLE at accept;
//   resp_data=1 on success, 0 otherwise (no bus op on failure). Lock is cleared when the
//   STx_C leaves IDLE, success or not.
//  Any plain store whose block matches lock_addr clears lock on mem_ready.
//  lock_clear clears lock every cycle it is high. If lock_clear coincides with STx_C
//   acceptance, clear wins and the STx_C fails. If it coincides with LDx_L lock set,
//   set wins.
//  Latency (zero-wait bus): load accept c0, mem_valid c1, rvalid c2, resp_valid c3;
//   store resp_valid c2; fault resp_valid c1.
//  resp_* held stable while resp_valid=1 && resp_ready=0.
// STRUCTURE
//  Shared header axp-mem.vh: opcode constants, status codes, FSM state encodings,
//   size-mask values.
//  Sub-module axp_ldext: combinational lane shift plus zero/sign-extend (rdata, offset,
//   mask, sext).
//  FSM, lock register and bus/response registers live in axp_lsu.
// TESTING
//  LDL 0x1004, rdata 0x80000000_00000000 -> resp_data 0xFFFFFFFF_80000000, status 0,
//   mem_addr 0x1000, be F0.
//  STB 0x2003, data 0xAB -> mem_be 08, mem_wdata 0x00000000_AB000000, mem_we=1;
//   resp_data 0 after mem_ready.
//  LDQ 0x3004 -> status 1, no mem_valid pulse; LDQ_U 0x3004 -> mem_addr 0x3000, be FF.
//  LDQ_L 0x4000; STQ_C 0x4008 -> write issued, resp_data 1. Repeat STQ_C -> resp_data 0,
//   no bus op.
//  LDL_L 0x5000, lock_clear pulse, STL_C 0x5000 -> resp_data 0. mem_ready held low 5 cycles
//   -> mem_* stable; req_ready=0.
//  reset_n low while in WAIT, then stray mem_rvalid -> no resp_valid; next request served
//   normally.

Source files
------------

// File: rtl/axp_lsu_pkg.sv
// Shared definitions for the load/store unit: opcode values, response status
// codes, size-mask values, FSM state encoding and the opcode decoder.
package axp_lsu_pkg;

    // Memory-format opcodes handled by the unit
    localparam logic [5:0] OP_LDBU  = 6'h0A;
    localparam logic [5:0] OP_LDQ_U = 6'h0B;
    localparam logic [5:0] OP_LDWU  = 6'h0C;
    localparam logic [5:0] OP_STW   = 6'h0D;
    localparam logic [5:0] OP_STB   = 6'h0E;
    localparam logic [5:0] OP_STQ_U = 6'h0F;
    localparam logic [5:0] OP_LDL   = 6'h28;
    localparam logic [5:0] OP_LDQ   = 6'h29;
    localparam logic [5:0] OP_LDL_L = 6'h2A;
    localparam logic [5:0] OP_LDQ_L = 6'h2B;
    localparam logic [5:0] OP_STL   = 6'h2C;
    localparam logic [5:0] OP_STQ   = 6'h2D;
    localparam logic [5:0] OP_STL_C = 6'h2E;
    localparam logic [5:0] OP_STQ_C = 6'h2F;

    // Response status codes
    localparam logic [1:0] STATUS_OK        = 2'd0;
    localparam logic [1:0] STATUS_UNALIGNED = 2'd1;
    localparam logic [1:0] STATUS_ILLEGAL   = 2'd2;

    // Size masks as delivered by the address/mask calculator
    localparam logic [7:0] MASK_BYTE = 8'h01;
    localparam logic [7:0] MASK_WORD = 8'h03;
    localparam logic [7:0] MASK_LONG = 8'h0F;
    localparam logic [7:0] MASK_QUAD = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic legal;    // opcode is a memory op this unit executes
        logic is_load;
        logic is_unal;  // LDQ_U/STQ_U: low address bits are discarded
        logic is_ldl;   // load-locked
        logic is_stc;   // store-conditional
        logic sext;     // longword loads sign-extend from bit 31
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '0;
        info.legal = 1'b1;
        case (op)
            OP_LDBU, OP_LDWU, OP_LDQ:  info.is_load = 1'b1;
            OP_LDQ_U:                  begin info.is_load = 1'b1; info.is_unal = 1'b1; end
            OP_LDL:                    begin info.is_load = 1'b1; info.sext = 1'b1; end
            OP_LDL_L:                  begin info.is_load = 1'b1; info.sext = 1'b1; info.is_ldl = 1'b1; end
            OP_LDQ_L:                  begin info.is_load = 1'b1; info.is_ldl = 1'b1; end
            OP_STW, OP_STB, OP_STL, OP_STQ: info.legal = 1'b1;
            OP_STQ_U:                  info.is_unal = 1'b1;
            OP_STL_C, OP_STQ_C:        info.is_stc = 1'b1;
            default:                   info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/axp_lsu_ldext.sv
// Load data extractor: shifts the addressed lane of a 64-bit read beat down to
// bit 0 and zero-extends (byte/word/long) or sign-extends (long with sext).
// Ports:
//   rdata  in  64  raw quadword from the bus
//   offset in  3   byte offset within the quadword
//   mask   in  8   size mask (01/03/0F/FF)
//   sext   in  1   sign-extend a longword from bit 31
//   data   out 64  right-justified, extended result
module axp_lsu_ldext
    import axp_lsu_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [7:0]  mask,
    input  logic        sext,
    output logic [63:0] data
);

    logic [63:0] shifted;
    logic [63:0] keep;

    assign shifted = rdata >> {offset, 3'b000};

    // Each size-mask bit keeps one byte of the shifted value
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_keep
            assign keep[gi*8 +: 8] = {8{mask[gi]}};
        end
    endgenerate

    always_comb begin
        data = shifted & keep;
        if (sext && mask == MASK_LONG) begin
            data = {{32{shifted[31]}}, shifted[31:0]};
        end
    end

endmodule

// File: rtl/axp_lsu.sv
// Load/store unit. Accepts one memory op at a time, checks opcode and alignment,
// drives a 64-bit quadword-aligned bus, and returns load data, store-conditional
// success, or a fault status. Holds the LDx_L/STx_C lock flag.
// Ports:
//   clock, reset_n                 clock and synchronous active-low reset
//   req_valid/ready/cmd/addr/mask/data   request channel (accepted in IDLE only)
//   mem_valid/ready/we/addr/be/wdata     bus request channel
//   mem_rvalid/rdata                     single-beat read return
//   lock_clear                           snoop hit, clears the lock flag
//   resp_valid/ready/data/status         result channel
module axp_lsu
    import axp_lsu_pkg::*;
#(
    parameter int LOCK_SHIFT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_cmd,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_mask,
    input  logic [63:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        lock_clear,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [1:0]  resp_status
);

    localparam int BLK_W = 64 - LOCK_SHIFT;

    lsu_state_e  state_reg, state_next;

    logic [2:0]       off_reg;
    logic [7:0]       mask_reg;
    logic [BLK_W-1:0] blk_reg;
    logic             sext_reg, is_ldl_reg, is_stc_reg;
    logic             mem_we_reg;
    logic [63:0]      mem_addr_reg, mem_wdata_reg, resp_data_reg;
    logic [7:0]       mem_be_reg;
    logic [1:0]       resp_status_reg;
    logic             lock_reg;
    logic [BLK_W-1:0] lock_addr_reg;

    // Only the opcode field matters here; the register fields are not consumed.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^req_cmd[25:0];

    // ---- request decode (meaningful only while accepting) ----
    op_info_t    req_info;
    logic [63:0] eff_addr;
    logic [2:0]  size_m1;
    logic        accept, unaligned, fault, stc_ok, issue_bus;

    assign req_info  = decode_op(req_cmd[31:26]);
    assign accept    = req_valid && (state_reg == S_IDLE);
    assign eff_addr  = req_info.is_unal ? {req_addr[63:3], 3'b000} : req_addr;
    // size-1 recovered from the mask: 01->0, 03->1, 0F->3, FF->7
    assign size_m1   = {req_mask[7], req_mask[3], req_mask[1]};
    assign unaligned = |(eff_addr[2:0] & size_m1);
    assign fault     = !req_info.legal || unaligned;
    // A same-cycle snoop clear beats the reservation check
    assign stc_ok    = lock_reg && !lock_clear && (lock_addr_reg == eff_addr[63:LOCK_SHIFT]);
    assign issue_bus = !fault && (!req_info.is_stc || stc_ok);

    logic [63:0] ld_data;

    axp_lsu_ldext u_ldext (
        .rdata  (mem_rdata),
        .offset (off_reg),
        .mask   (mask_reg),
        .sext   (sext_reg),
        .data   (ld_data)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clock) begin
        if (!reset_n) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept)     state_next = issue_bus ? S_REQ : S_RESP;
            S_REQ:  if (mem_ready)  state_next = mem_we_reg ? S_RESP : S_WAIT;
            S_WAIT: if (mem_rvalid) state_next = S_RESP;
            S_RESP: if (resp_ready) state_next = S_IDLE;
            default:                state_next = S_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        req_ready  = (state_reg == S_IDLE);
        mem_valid  = (state_reg == S_REQ);
        resp_valid = (state_reg == S_RESP);
    end

    assign mem_we      = mem_we_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_be      = mem_be_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign resp_data   = resp_data_reg;
    assign resp_status = resp_status_reg;

    // ---- request capture, bus and response registers ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            off_reg         <= '0;
            mask_reg        <= '0;
            blk_reg         <= '0;
            sext_reg        <= 1'b0;
            is_ldl_reg      <= 1'b0;
            is_stc_reg      <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_addr_reg    <= '0;
            mem_be_reg      <= '0;
            mem_wdata_reg   <= '0;
            resp_data_reg   <= '0;
            resp_status_reg <= STATUS_OK;
        end else begin
            if (accept) begin
                off_reg         <= eff_addr[2:0];
                mask_reg        <= req_mask;
                blk_reg         <= eff_addr[63:LOCK_SHIFT];
                sext_reg        <= req_info.sext;
                is_ldl_reg      <= req_info.is_ldl;
                is_stc_reg      <= req_info.is_stc;
                mem_we_reg      <= !req_info.is_load;
                mem_addr_reg    <= {eff_addr[63:3], 3'b000};
                mem_be_reg      <= req_mask << eff_addr[2:0];
                mem_wdata_reg   <= req_data << {eff_addr[2:0], 3'b000};
                resp_data_reg   <= '0;
                resp_status_reg <= !req_info.legal ? STATUS_ILLEGAL :
                                   unaligned       ? STATUS_UNALIGNED : STATUS_OK;
            end
            if (state_reg == S_REQ && mem_ready && mem_we_reg) begin
                resp_data_reg <= {63'd0, is_stc_reg};
            end
            if (state_reg == S_WAIT && mem_rvalid) begin
                resp_data_reg <= ld_data;
            end
        end
    end

    // ---- lock flag ----
    logic ldl_set, stc_accept, plain_st_hit;

    assign ldl_set      = (state_reg == S_WAIT) && mem_rvalid && is_ldl_reg;
    assign stc_accept   = accept && req_info.is_stc;
    assign plain_st_hit = (state_reg == S_REQ) && mem_ready && mem_we_reg && !is_stc_reg &&
                          (lock_addr_reg == blk_reg);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            lock_reg      <= 1'b0;
            lock_addr_reg <= '0;
        end else if (ldl_set) begin
            // setting the reservation outranks a concurrent snoop clear
            lock_reg      <= 1'b1;
            lock_addr_reg <= blk_reg;
        end else if (lock_clear || stc_accept || plain_st_hit) begin
            lock_reg      <= 1'b0;
        end
    end

endmodule
